mem_access: RTL and testbench



---
 rtl/lc3_pkg.sv | 41 ++++
 rtl/mem_access.sv | 133 +++++++++++++
 tb/tb_mem_access.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC3 definitions: opcode constants, memory-stage state type and opcode classifiers.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StIndRd,
        StDataRd,
        StDataWr,
        StFin
    } ma_state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/mem_access.sv
// LC3 memory-access stage: runs direct and indirect loads/stores over a req/ready port
// and returns load data for writeback and the execute bypass.
module mem_access
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] IR_Exec,
    input  logic [15:0] pcout,
    input  logic [15:0] M_Data,
    input  logic [2:0]  dr_in,
    input  logic [1:0]  W_Control_in,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        done,
    output logic [15:0] memout,
    output logic [15:0] Mem_Bypass_val,
    output logic [2:0]  dr_out,
    output logic [1:0]  W_Control_out
);

    ma_state_t   r_state;
    ma_state_t   w_state_next;
    logic [3:0]  w_op;
    logic        w_unused_ir;

    logic [3:0]  r_op;
    logic        r_req;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_memout;
    logic [2:0]  r_dr;
    logic [1:0]  r_wc;

    assign w_op        = IR_Exec[15:12];
    assign w_unused_ir = ^IR_Exec[11:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (start) begin
                    if (is_indirect(w_op))   w_state_next = StIndRd;
                    else if (is_load(w_op))  w_state_next = StDataRd;
                    else if (is_store(w_op)) w_state_next = StDataWr;
                    else                     w_state_next = StFin;
                end
            end
            StIndRd: begin
                if (mem_ready) w_state_next = is_store(r_op) ? StDataWr : StDataRd;
            end
            StDataRd: begin
                if (mem_ready) w_state_next = StFin;
            end
            StDataWr: begin
                if (mem_ready) w_state_next = StFin;
            end
            StFin:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Memory-port registers only move on start or on an observed mem_ready, so the
    // request stays stable across wait cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_op     <= 4'd0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 16'd0;
            r_wdata  <= 16'd0;
            r_memout <= 16'd0;
            r_dr     <= 3'd0;
            r_wc     <= 2'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_op    <= w_op;
                        r_dr    <= dr_in;
                        r_wc    <= W_Control_in;
                        r_wdata <= M_Data;
                        if (w_state_next != StFin) begin
                            r_req  <= 1'b1;
                            r_addr <= pcout;
                            r_we   <= (w_state_next == StDataWr);
                        end
                    end
                end
                StIndRd: begin
                    if (mem_ready) begin
                        r_addr <= mem_rdata;
                        r_we   <= (w_state_next == StDataWr);
                    end
                end
                StDataRd: begin
                    if (mem_ready) begin
                        r_memout <= mem_rdata;
                        r_req    <= 1'b0;
                    end
                end
                StDataWr: begin
                    if (mem_ready) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy           = (r_state != StIdle);
    assign done           = (r_state == StFin);
    assign mem_req        = r_req;
    assign mem_we         = r_we;
    assign mem_addr       = r_addr;
    assign mem_wdata      = r_wdata;
    assign memout         = r_memout;
    assign Mem_Bypass_val = r_memout;
    assign dr_out         = r_dr;
    assign W_Control_out  = r_wc;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a behavioural memory that inserts a programmable
// number of wait cycles per request.
module tb_mem_access;
    import lc3_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] IR_Exec;
    logic [15:0] pcout;
    logic [15:0] M_Data;
    logic [2:0]  dr_in;
    logic [1:0]  W_Control_in;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        done;
    logic [15:0] memout;
    logic [15:0] Mem_Bypass_val;
    logic [2:0]  dr_out;
    logic [1:0]  W_Control_out;

    logic [15:0] tb_mem [0:65535];
    logic [15:0] log_addr  [0:15];
    logic        log_we    [0:15];
    logic [15:0] log_wdata [0:15];

    int n_checks;
    int n_fail;
    int n_xact;
    int n_done;
    int wait_n;
    int wait_cnt;

    mem_access u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .IR_Exec        (IR_Exec),
        .pcout          (pcout),
        .M_Data         (M_Data),
        .dr_in          (dr_in),
        .W_Control_in   (W_Control_in),
        .busy           (busy),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .done           (done),
        .memout         (memout),
        .Mem_Bypass_val (Mem_Bypass_val),
        .dr_out         (dr_out),
        .W_Control_out  (W_Control_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr];
    assign mem_ready = mem_req && (wait_cnt >= wait_n);

    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            log_addr[n_xact[3:0]]  <= mem_addr;
            log_we[n_xact[3:0]]    <= mem_we;
            log_wdata[n_xact[3:0]] <= mem_wdata;
            n_xact   <= n_xact + 1;
            wait_cnt <= 0;
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Presents one start pulse; returns in cycle 1 (just after the start edge).
    task automatic start_op(input logic [3:0] op, input logic [15:0] addr,
                            input logic [15:0] data, input logic [2:0] dr,
                            input logic [1:0] wc);
        IR_Exec      = {op, 12'h0A5};
        pcout        = addr;
        M_Data       = data;
        dr_in        = dr;
        W_Control_in = wc;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int x0;
        int x1;
        int d0;

        n_checks = 0;
        n_fail   = 0;
        n_xact   = 0;
        n_done   = 0;
        wait_n   = 0;
        wait_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        IR_Exec  = 16'd0;
        pcout    = 16'd0;
        M_Data   = 16'd0;
        dr_in    = 3'd0;
        W_Control_in = 2'd0;

        tb_mem[16'h3005] = 16'hBEEF;
        tb_mem[16'h3010] = 16'h4000;
        tb_mem[16'h3020] = 16'h5000;
        tb_mem[16'h5000] = 16'h00FF;
        tb_mem[16'h3030] = 16'hA5A5;
        tb_mem[16'h3040] = 16'h7777;

        tick();
        tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_req", mem_req, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_memout", memout, 0);
        check_eq("rst_bypass", Mem_Bypass_val, 0);
        check_eq("rst_dr", dr_out, 0);
        check_eq("rst_wc", W_Control_out, 0);
        rst_n = 1'b1;
        tick();

        // LD, zero wait
        start_op(OP_LD, 16'h3005, 16'h0000, 3'd5, 2'b10);
        check_eq("ld_req_c1", mem_req, 1);
        check_eq("ld_we_c1", mem_we, 0);
        check_eq("ld_addr_c1", mem_addr, 16'h3005);
        check_eq("ld_busy_c1", busy, 1);
        check_eq("ld_done_c1", done, 0);
        tick();
        check_eq("ld_done_c2", done, 1);
        check_eq("ld_memout", memout, 16'hBEEF);
        check_eq("ld_bypass", Mem_Bypass_val, 16'hBEEF);
        check_eq("ld_dr", dr_out, 5);
        check_eq("ld_wc", W_Control_out, 2);
        tick();
        check_eq("ld_done_c3", done, 0);
        check_eq("ld_busy_c3", busy, 0);
        check_eq("ld_memout_hold", memout, 16'hBEEF);

        // STI, two wait cycles per access
        wait_n = 2;
        x0 = n_xact;
        start_op(OP_STI, 16'h3010, 16'h1234, 3'd3, 2'b00);
        wait_done(cyc);
        check_eq("sti_done_cyc", cyc, 7);
        check_eq("sti_memout", memout, 16'hBEEF);
        tick();
        x1 = x0 + 1;
        check_eq("sti_nxact", n_xact - x0, 2);
        check_eq("sti_rd_addr", log_addr[x0[3:0]], 16'h3010);
        check_eq("sti_rd_we", log_we[x0[3:0]], 0);
        check_eq("sti_wr_addr", log_addr[x1[3:0]], 16'h4000);
        check_eq("sti_wr_we", log_we[x1[3:0]], 1);
        check_eq("sti_wr_data", log_wdata[x1[3:0]], 16'h1234);

        // LDI, zero wait
        wait_n = 0;
        x0 = n_xact;
        start_op(OP_LDI, 16'h3020, 16'h0000, 3'd1, 2'b01);
        wait_done(cyc);
        check_eq("ldi_done_cyc", cyc, 3);
        check_eq("ldi_memout", memout, 16'h00FF);
        check_eq("ldi_bypass", Mem_Bypass_val, 16'h00FF);
        tick();
        x1 = x0 + 1;
        check_eq("ldi_nxact", n_xact - x0, 2);
        check_eq("ldi_ptr_addr", log_addr[x0[3:0]], 16'h3020);
        check_eq("ldi_data_addr", log_addr[x1[3:0]], 16'h5000);

        // LD with three wait cycles and a second start dropped mid-wait
        wait_n = 3;
        x0 = n_xact;
        d0 = n_done;
        start_op(OP_LD, 16'h3030, 16'h0000, 3'd6, 2'b11);
        IR_Exec = {OP_LD, 12'h000};
        pcout   = 16'h3040;
        dr_in   = 3'd2;
        start   = 1'b1;
        check_eq("stall_addr_c1", mem_addr, 16'h3030);
        tick();
        start = 1'b0;
        cyc = 2;
        while (!done && cyc < 40) begin
            check_eq("stall_addr", mem_addr, 16'h3030);
            check_eq("stall_req", mem_req, 1);
            tick();
            cyc++;
        end
        check_eq("stall_done_cyc", cyc, 5);
        check_eq("stall_memout", memout, 16'hA5A5);
        check_eq("stall_dr", dr_out, 6);
        tick();
        check_eq("stall_idle", busy, 0);
        check_eq("stall_ndone", n_done - d0, 1);
        check_eq("stall_nxact", n_xact - x0, 1);
        tick();
        check_eq("stall_no_queue", busy, 0);

        // Asynchronous reset during DATA_RD
        wait_n = 5;
        d0 = n_done;
        start_op(OP_LD, 16'h3005, 16'h0000, 3'd2, 2'b01);
        tick();
        check_eq("rstmid_req_pre", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_req", mem_req, 0);
        check_eq("rstmid_busy", busy, 0);
        check_eq("rstmid_memout", memout, 0);
        check_eq("rstmid_bypass", Mem_Bypass_val, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("rstmid_ndone", n_done - d0, 0);
        check_eq("rstmid_idle", busy, 0);
        wait_n = 0;
        start_op(OP_LD, 16'h3005, 16'h0000, 3'd4, 2'b10);
        wait_done(cyc);
        check_eq("postrst_done_cyc", cyc, 2);
        check_eq("postrst_memout", memout, 16'hBEEF);
        tick();

        // Non-memory opcode
        x0 = n_xact;
        start_op(OP_ADD, 16'h3005, 16'h0000, 3'd7, 2'b11);
        check_eq("add_req", mem_req, 0);
        check_eq("add_done_c1", done, 1);
        check_eq("add_busy_c1", busy, 1);
        tick();
        check_eq("add_busy_c2", busy, 0);
        check_eq("add_done_c2", done, 0);
        check_eq("add_memout", memout, 16'hBEEF);
        check_eq("add_nxact", n_xact - x0, 0);
        check_eq("add_dr", dr_out, 7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
